// File: rtl/code_lock_pkg.sv
// Shared types and constants for the serial code lock.
// State encoding is visible on the state output port, so the values here are fixed.
package code_lock_pkg;

    localparam int STATE_W = 2;
    localparam int FAIL_W  = 4;
    localparam int TIMER_W = 16;

    localparam logic [FAIL_W-1:0] FAIL_SAT = 4'd15;

    typedef enum logic [STATE_W-1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } state_t;

    // A keypad bit is valid only when exactly one of the two bit lines is high.
    function automatic logic bit_valid(input logic zero, input logic one);
        return zero ^ one;
    endfunction

endpackage

// File: rtl/code_lock_fsm_lockout_timer.sv
// Down-counter that holds the lock in LOCKOUT for a fixed number of cycles.
// done pulses combinationally on the cycle whose edge brings the count to zero.
module lockout_timer
    import code_lock_pkg::*;
#(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic done
);

    logic [TIMER_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= TIMER_W'(CYCLES);
        end else if (count && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = count && (cnt_q == TIMER_W'(1));

endmodule

// File: rtl/code_lock_fsm.sv
// Serial code lock: bits are keyed in one per cycle and compared as a whole entry.
// Lockout after repeated failures exists only when CODE_LOCK_LOCKOUT_EN is defined.
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int unsigned         CODE_LEN       = 5,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 5'b01011,
    parameter int unsigned         MAX_FAILS      = 3,
    parameter int unsigned         LOCKOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          zero,
    input  logic                          one,
    input  logic                          relock,
    input  logic                          prog_en,
    input  logic [CODE_LEN-1:0]           prog_code,
    output logic                          unlocked,
    output logic                          alarm,
    output logic [STATE_W-1:0]            state,
    output logic [$clog2(CODE_LEN+1)-1:0] bit_cnt,
    output logic [FAIL_W-1:0]             fail_cnt
);

    // state    | meaning
    // ---------+-----------------------------------------------------
    // LOCKED   | collecting bits; full entry compared on the last bit
    // UNLOCKED | bits ignored; code may be reprogrammed; relock exits
    // LOCKOUT  | all inputs ignored until the lockout timer expires

    localparam int BW = $clog2(CODE_LEN + 1);

    if (CODE_LEN < 2 || CODE_LEN > 16) begin : g_bad_code_len
        $error("CODE_LEN must be in 2..16");
    end
    if (MAX_FAILS < 1 || MAX_FAILS > 15) begin : g_bad_max_fails
        $error("MAX_FAILS must be in 1..15");
    end
    if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535) begin : g_bad_lockout
        $error("LOCKOUT_CYCLES must be in 1..65535");
    end

    state_t                state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FAIL_W-1:0]     fail_q, fail_d;
    logic [CODE_LEN-1:0]   entry_q, entry_d;
    logic [CODE_LEN-1:0]   code_q, code_d;
    logic                  unlocked_q;
    logic                  alarm_q;

    logic                  in_valid;
    logic                  last_bit;
    logic [CODE_LEN-1:0]   full_entry;
    logic [FAIL_W-1:0]     fail_inc;

`ifdef CODE_LOCK_LOCKOUT_EN
    logic timer_load;
    logic timer_done;

    lockout_timer #(
        .CYCLES (LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .count (state_q == LOCKOUT),
        .done  (timer_done)
    );
`endif

    assign in_valid   = bit_valid(zero, one);
    assign last_bit   = (bit_cnt_q == BW'(CODE_LEN - 1));
    assign full_entry = {entry_q[CODE_LEN-2:0], one};
    assign fail_inc   = (fail_q == FAIL_SAT) ? fail_q : fail_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        fail_d    = fail_q;
        entry_d   = entry_q;
        code_d    = code_q;
`ifdef CODE_LOCK_LOCKOUT_EN
        timer_load = 1'b0;
`endif
        case (state_q)
            LOCKED: begin
                // relock wins over a simultaneous bit: the attempt is abandoned, not failed
                if (relock) begin
                    bit_cnt_d = '0;
                end else if (in_valid) begin
                    entry_d = full_entry;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (full_entry == code_q) begin
                            state_d = UNLOCKED;
                            fail_d  = '0;
                        end else begin
                            fail_d = fail_inc;
`ifdef CODE_LOCK_LOCKOUT_EN
                            if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                                state_d    = LOCKOUT;
                                timer_load = 1'b1;
                            end
`endif
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            UNLOCKED: begin
                if (prog_en) begin
                    code_d = prog_code;
                end
                if (relock) begin
                    state_d   = LOCKED;
                    bit_cnt_d = '0;
                end
            end
            LOCKOUT: begin
`ifdef CODE_LOCK_LOCKOUT_EN
                if (timer_done) begin
                    state_d   = LOCKED;
                    fail_d    = '0;
                    bit_cnt_d = '0;
                end
`else
                state_d = LOCKED;
`endif
            end
            default: begin
                state_d   = LOCKED;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOCKED;
            bit_cnt_q  <= '0;
            fail_q     <= '0;
            entry_q    <= '0;
            code_q     <= DEFAULT_CODE;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            fail_q     <= fail_d;
            entry_q    <= entry_d;
            code_q     <= code_d;
            unlocked_q <= (state_d == UNLOCKED);
            alarm_q    <= (state_d == LOCKOUT);
        end
    end

    assign state    = state_q;
    assign unlocked = unlocked_q;
    assign bit_cnt  = bit_cnt_q;
    assign fail_cnt = fail_q;
`ifdef CODE_LOCK_LOCKOUT_EN
    assign alarm    = alarm_q;
`else
    assign alarm    = 1'b0;
`endif

endmodule
